// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - FWFT result/flag FIFO behind the ALU core; optional flag statistics under ALU_FIFO_FLAG_STAT_EN
module alu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_result,
    input  logic [3:0]               i_flag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_result,
    output logic [3:0]               o_flag,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [7:0]               o_err_cnt,
    output logic [7:0]               o_ovf_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WIDTH + 4;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Each entry packs {flag, result}; contents are never reset because
    // the head is masked to zero whenever the queue is empty.
    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Status comes from the occupancy register only, never from pointers.
    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_ready = !o_full;
    assign o_valid = !o_empty;
    assign o_count = count_q;
    assign o_drop  = drop_q;

    // A full FIFO refuses input even when the head is popped that cycle.
    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    // Head entry falls through combinationally, forced to zero while empty.
    always_comb begin
        head = '0;
        if (!o_empty) begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign o_result = head[WIDTH-1:0];
    assign o_flag   = head[EW-1:WIDTH];

    // Next-state for pointers, occupancy and the sticky drop bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (i_valid && o_full) begin
            drop_d = 1'b1;
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage write; flag combinations are kept verbatim.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_flag, i_result};
        end
    end

`ifdef ALU_FIFO_FLAG_STAT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating counts of accepted entries carrying err / overflow flags.
    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push && i_flag[0] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (push && i_flag[3] && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    // Statistic registers, cleared with the rest of the control state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_cnt_q <= 8'd0;
            ovf_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
    assign o_ovf_cnt = ovf_cnt_q;
`else
    assign o_err_cnt = 8'd0;
    assign o_ovf_cnt = 8'd0;
`endif

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Buffering stage directly downstream of the registered ALU core. It captures each registered result/flag pair, holds up to DEPTH entries in a first-word-fall-through queue, and presents them to a consumer over a valid/ready handshake. It reports occupancy and a sticky drop indication. Optionally, it keeps saturating counts of error and overflow flags.

## Interface
- WIDTH, 4, result width; matches the ALU core result width
- DEPTH, 4, number of entries; power of two, ≥2
- i_clk  input  1  clock; all state updates on the rising edge
- i_rstn  input  1  reset, asynchronous, active-low
- i_valid  input  1  producer has a result/flag pair this cycle
- o_ready  output  1  FIFO can accept a pair this cycle
- i_result  input  WIDTH  signed ALU result
- i_flag  input  4  ALU flags: [0] err, [1] neg, [2] pos, [3] overflow
- o_valid  output  1  head entry is available
- i_ready  input  1  consumer takes the head entry this cycle
- o_result  output  WIDTH  head result
- o_flag  output  4  head flags
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_full  output  1  o_count == DEPTH
- o_empty  output  1  o_count == 0
- o_drop  output  1  sticky: a pair was offered while full
- o_err_cnt  output  8  accepted entries with flag[0]=1 (see Configuration)
- o_ovf_cnt  output  8  accepted entries with flag[3]=1 (see Configuration)

## Operation
- Push occurs when i_valid && o_ready. The pair is written at the write pointer, and the pointer advances modulo DEPTH.
- Pop occurs when o_valid && i_ready. The read pointer advances modulo DEPTH.
- Output and status relations:
  - o_ready = !o_full.
  - o_valid = !o_empty.
  - o_result/o_flag are driven combinationally from the storage entry at the read pointer.
  - When empty, o_result/o_flag are forced to 0.
- Occupancy update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, and both pointers advance.
- Full boundary: o_ready=0, so a simultaneous pop does not enable a push that cycle. The offered pair is lost and o_drop sets.
- Empty boundary: a push and an i_ready in the same cycle do not pop, because o_valid=0. The entry becomes visible on the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from o_count, not from pointer comparison.
- o_drop sets on i_valid && o_full and clears only on reset.
- Stored data is not checked: flag combinations are stored verbatim.

## Timing
- Reset (asynchronous, any cycle, including mid-transfer) clears:
  - pointers and o_count;
  - o_drop, o_err_cnt, o_ovf_cnt.
- Immediately after reset assertion the outputs are: o_valid=0, o_ready=1, o_empty=1, o_full=0, o_result=0, o_flag=0.
- Storage contents are not reset and are unobservable while empty.
- Latency: a pair pushed at edge N is presented on o_result/o_flag with o_valid=1 after edge N.
- Throughput: one push and one pop per cycle sustained, provided the FIFO is not full.
- o_count, o_full and o_empty are registered-state-derived and update after the edge.
- The producer must hold i_result/i_flag stable while i_valid=1 && o_ready=0. The same obligation applies to the consumer side for o_valid.

## Configuration
- Macro: ALU_FIFO_FLAG_STAT_EN.
- Defined:
  - o_err_cnt increments on each push with i_flag[0]=1.
  - o_ovf_cnt increments on each push with i_flag[3]=1.
  - Both count pushes only, never dropped pairs.
  - Both saturate at 255 and clear on reset.
  - One push with both flags set increments both counters.
- Undefined:
  - Counter registers are not built.
  - o_err_cnt and o_ovf_cnt are tied to 8'd0.
  - Ports are always present.

## Test plan
- Reset then idle → o_valid=0, o_ready=1, o_count=0, o_result=0, o_flag=0; then assert i_rstn low mid-stream with 2 entries → o_count=0 and o_valid=0 immediately.
- Push result=4'sd3, flag=4'b0100 with i_ready=0 → next cycle o_valid=1, o_result=3, o_flag=4'b0100, o_count=1; assert i_ready → o_empty=1 next cycle.
- Push results 1,2,3,4 (DEPTH=4), i_ready=0 → o_full=1, o_ready=0. Offer 5 → o_drop=1, o_count=4. Pop all four → the sequence is 1,2,3,4, never 5.
- Continuous push of 0..9 with i_ready=1 every cycle → o_count stays at 1 after the first push; all ten values are popped in order; the pointers wrap twice with no loss.
- Empty FIFO, i_valid=1 and i_ready=1 in the same cycle → no pop that cycle; next cycle o_valid=1 with the pushed data.
- ALU_FIFO_FLAG_STAT_EN defined:
  - 300 pushes with flag=4'b1001 → o_err_cnt=255, o_ovf_cnt=255.
  - A drop with flag=4'b0001 → counters unchanged.
  - With the macro undefined, both counters read 0.
